// File: rtl/thirty_two_bit_divide_pkg.sv
// thirty_two_bit_divide_pkg: shared mult/div constants, state encoding and helpers.
package thirty_two_bit_divide_pkg;
  localparam int WIDTH = 32;
  localparam int ITER = 32;
  localparam int CNT_W = $clog2(ITER) + 1;
  localparam logic [WIDTH-1:0] OVF_DIVIDEND = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  // 0x80000000 maps to 2^31, which still fits as an unsigned 32-bit magnitude
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
endpackage

// File: rtl/thirty_two_bit_divide_if.sv
// thirty_two_bit_divide_if: operand/strobe and result bundle of the divider.
interface thirty_two_bit_divide_if;
  import thirty_two_bit_divide_pkg::*;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic do_div;
  logic value_ready;
  logic exception;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] remainder;
  modport master(output A, B, do_div, input value_ready, exception, out, remainder);
  modport slave(input A, B, do_div, output value_ready, exception, out, remainder);
endinterface

// File: rtl/thirty_two_bit_divide_div_step.sv
// div_step: one combinational restoring shift/subtract step on unsigned magnitudes.
module div_step
  import thirty_two_bit_divide_pkg::*;
(
  input  logic [WIDTH:0]   partial_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   partial_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  always_comb begin
    shifted = {partial_in, bit_in};
    trial = shifted - {2'b00, divisor};
    q_bit = ~trial[WIDTH+1];
    partial_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/thirty_two_bit_divide.sv
// thirty_two_bit_divide: multi-cycle signed divider with MIPS DIV semantics.
// One quotient bit per BUSY cycle; sign fix-up and exception flags applied on DONE entry.
module thirty_two_bit_divide
  import thirty_two_bit_divide_pkg::*;
(
  input logic clk,
  input logic reset,
  thirty_two_bit_divide_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] partial_nxt;
  logic [CNT_W-1:0] cnt;
  logic q_bit;
  logic neg_q;
  logic neg_r;
  logic ovf;
  div_step u_step (
    .partial_in(partial),
    .bit_in(q[WIDTH-1]),
    .divisor(d),
    .partial_out(partial_nxt),
    .q_bit(q_bit)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      d <= '0;
      partial <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf <= 1'b0;
      bus.out <= '0;
      bus.remainder <= '0;
      bus.value_ready <= 1'b0;
      bus.exception <= 1'b0;
    end else if (bus.do_div) begin
      q <= mag(bus.A);
      d <= mag(bus.B);
      neg_r <= bus.A[WIDTH-1];
      neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      ovf <= (bus.A == OVF_DIVIDEND) && (bus.B == '1);
      partial <= '0;
      cnt <= '0;
      bus.value_ready <= 1'b0;
      bus.exception <= 1'b0;
      state <= (bus.B == '0) ? DONE : BUSY;
    end else if (state == BUSY && cnt == CNT_W'(ITER)) begin
      state <= DONE;
      bus.out <= neg_q ? -q : q;
      bus.remainder <= neg_r ? -partial[WIDTH-1:0] : partial[WIDTH-1:0];
      bus.exception <= ovf;
      bus.value_ready <= 1'b1;
    end else if (state == BUSY) begin
      partial <= partial_nxt;
      q <= {q[WIDTH-2:0], q_bit};
      cnt <= cnt + 1'b1;
    end else if (state == DONE && !bus.value_ready) begin
      // only the divide-by-zero path reaches DONE without a posted result; q still holds |A|
      bus.out <= '0;
      bus.remainder <= neg_r ? -q : q;
      bus.exception <= 1'b1;
      bus.value_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_thirty_two_bit_divide.sv
// tb_thirty_two_bit_divide: directed vectors with hand-computed quotient/remainder.
module tb_thirty_two_bit_divide;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  logic seen;
  thirty_two_bit_divide_if bus ();
  thirty_two_bit_divide dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.do_div = 1'b1;
    @(negedge clk);
    bus.do_div = 1'b0;
    seen = bus.value_ready;
  endtask
  task automatic wait_busy(input int n);
    repeat (n) begin
      @(negedge clk);
      seen = seen | bus.value_ready;
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee, input int lat);
    start(a, b);
    wait_busy(lat - 1);
    check({tag, " early_ready"}, {31'b0, seen}, 32'd0);
    @(negedge clk);
    check({tag, " ready"}, {31'b0, bus.value_ready}, 32'd1);
    check({tag, " out"}, bus.out, eq);
    check({tag, " rem"}, bus.remainder, er);
    check({tag, " exc"}, {31'b0, bus.exception}, {31'b0, ee});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.do_div = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", {31'b0, bus.value_ready}, 32'd0);
    check("rst exc", {31'b0, bus.exception}, 32'd0);
    check("rst out", bus.out, 32'd0);
    check("rst rem", bus.remainder, 32'd0);
    reset = 1'b0;
    run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    repeat (5) @(negedge clk);
    check("hold ready", {31'b0, bus.value_ready}, 32'd1);
    check("hold out", bus.out, 32'd14);
    run_op("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    run_op("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("7/0", 32'd7, 32'd0, 32'd0, 32'd7, 1'b1, 1);
    run_op("-7/0", 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFF9, 1'b1, 1);
    run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33);
    run_op("min/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_op("-1/min", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("max/3", 32'h7FFF_FFFF, 32'd3, 32'h2AAA_AAAA, 32'd1, 1'b0, 33);
    start(32'd100, 32'd7);
    wait_busy(9);
    check("abort early_ready", {31'b0, seen}, 32'd0);
    run_op("abort 50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);
    start(32'd100, 32'd7);
    wait_busy(19);
    check("busy keeps out", bus.out, 32'd10);
    #2 reset = 1'b1;
    #1;
    check("async rst ready", {31'b0, bus.value_ready}, 32'd0);
    check("async rst out", bus.out, 32'd0);
    check("async rst rem", bus.remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    wait_busy(40);
    check("idle after rst", {31'b0, seen}, 32'd0);
    run_op("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
